// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative radix-2 shift-add multiplier for the Execute stage.
// Handles MUL (low word) and UMULL (full 2*WIDTH product), stalls the pipeline
// while iterating, and presents the result plus N/Z flags for one DONE cycle.
// Optional build macro: MUL_EARLY_TERM_EN finishes as soon as the remaining
// multiplier bits are all zero, giving operand-dependent latency.
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_Start,
    input  logic             i_Long,
    input  logic             i_Set_Flags,
    input  logic             i_Flush,
    input  logic [WIDTH-1:0] i_Op_A,
    input  logic [WIDTH-1:0] i_Op_B,
    output logic             o_Busy,
    output logic             o_Stall,
    output logic             o_Done,
    output logic [WIDTH-1:0] o_Result_Lo,
    output logic [WIDTH-1:0] o_Result_Hi,
    output logic             o_N,
    output logic             o_Z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_next;

    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 long_q;
    logic                 flags_q;

    logic [WIDTH-1:0]     result_lo;
    logic [WIDTH-1:0]     result_hi;
    logic                 n_q;
    logic                 z_q;

    logic [2*WIDTH-1:0]   acc_sum;
    logic                 load;
    logic                 last_iter;
    logic                 finish;

    // Accumulator value after this cycle's conditional add of the shifted multiplicand
    always_comb begin
        acc_sum = mplier[0] ? (acc + mcand) : acc;
    end

    // A new operation is accepted only outside RUN and never in a flush cycle
    always_comb begin
        load = (state != RUN) && i_Start && !i_Flush;
    end

    // Decide whether the current RUN cycle is the final iteration
    always_comb begin
        last_iter = (cnt == LAST_CNT);
`ifdef MUL_EARLY_TERM_EN
        if (mplier[WIDTH-1:1] == '0) begin
            last_iter = 1'b1;
        end
`endif
    end

    // Next-state and control outputs for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_next = state;
        o_Busy     = 1'b0;
        o_Stall    = 1'b0;
        o_Done     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                o_Stall = load;
                if (load) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                o_Busy  = 1'b1;
                o_Stall = 1'b1;
                if (i_Flush) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                o_Done     = 1'b1;
                o_Stall    = load;
                state_next = load ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Multiply datapath: load operands on acceptance, shift-add while running
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            long_q  <= 1'b0;
            flags_q <= 1'b0;
        end else if (load) begin
            mcand   <= {{WIDTH{1'b0}}, i_Op_A};
            mplier  <= i_Op_B;
            acc     <= '0;
            cnt     <= '0;
            long_q  <= i_Long;
            flags_q <= i_Set_Flags;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Commit result and optional flags on the edge that enters DONE; held until the next completion
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            result_lo <= '0;
            result_hi <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
        end else if (finish) begin
            result_lo <= acc_sum[WIDTH-1:0];
            result_hi <= long_q ? acc_sum[2*WIDTH-1:WIDTH] : '0;
            if (flags_q) begin
                if (long_q) begin
                    n_q <= acc_sum[2*WIDTH-1];
                    z_q <= (acc_sum == '0);
                end else begin
                    n_q <= acc_sum[WIDTH-1];
                    z_q <= (acc_sum[WIDTH-1:0] == '0);
                end
            end
        end
    end

    assign o_Result_Lo = result_lo;
    assign o_Result_Hi = result_hi;
    assign o_N         = n_q;
    assign o_Z         = z_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and randomized bench for mul_sequencer.
// A cycle-level behavioural model (product via plain multiplication, latency
// as a countdown) is compared against the DUT on every cycle.
module tb_mul_sequencer;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              long_op = 1'b0;
    logic              set_flags = 1'b0;
    logic              flush = 1'b0;
    logic [WIDTH-1:0]  op_a = '0;
    logic [WIDTH-1:0]  op_b = '0;

    logic              busy;
    logic              stall;
    logic              done;
    logic [WIDTH-1:0]  res_lo;
    logic [WIDTH-1:0]  res_hi;
    logic              flag_n;
    logic              flag_z;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    bit          m_running   = 1'b0;
    bit          m_done      = 1'b0;
    int          m_remaining = 0;
    logic [63:0] m_prod      = '0;
    bit          m_long      = 1'b0;
    bit          m_sf        = 1'b0;
    logic [31:0] m_lo        = '0;
    logic [31:0] m_hi        = '0;
    bit          m_n         = 1'b0;
    bit          m_z         = 1'b0;

    mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_Start     (start),
        .i_Long      (long_op),
        .i_Set_Flags (set_flags),
        .i_Flush     (flush),
        .i_Op_A      (op_a),
        .i_Op_B      (op_b),
        .o_Busy      (busy),
        .o_Stall     (stall),
        .o_Done      (done),
        .o_Result_Lo (res_lo),
        .o_Result_Hi (res_hi),
        .o_N         (flag_n),
        .o_Z         (flag_z)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Number of RUN cycles an operation with multiplier b occupies
    function automatic int run_cycles(input logic [31:0] b);
        int runs;
        runs = WIDTH;
        if (^b === 1'bx) runs = WIDTH;
`ifdef MUL_EARLY_TERM_EN
        runs = 1;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) runs = i + 1;
        end
`endif
        return runs;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, shortly after the rising edge
    task automatic applyStimulus(input bit r, input bit s, input bit l, input bit sf, input bit fl,
                                 input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        rst       = r;
        start     = s;
        long_op   = l;
        set_flags = sf;
        flush     = fl;
        op_a      = a;
        op_b      = b;
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Issue idle cycles until o_Done, returning the cycle index relative to the start cycle
    task automatic wait_done(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 200; i++) begin
            idle_cycle();
            @(negedge clk);
            if (done === 1'b1) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        checkOutput("done_within_bound", {63'd0, seen}, 64'd1);
    endtask

    // Per-cycle comparison against the model, then advance the model one cycle
    initial begin
        bit next_done;
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("busy",  {63'd0, busy},  {63'd0, m_running});
                checkOutput("stall", {63'd0, stall}, {63'd0, (m_running || (start && !flush))});
                checkOutput("done",  {63'd0, done},  {63'd0, m_done});
                checkOutput("lo",    {32'd0, res_lo}, {32'd0, m_lo});
                checkOutput("hi",    {32'd0, res_hi}, {32'd0, m_hi});
                checkOutput("n",     {63'd0, flag_n}, {63'd0, m_n});
                checkOutput("z",     {63'd0, flag_z}, {63'd0, m_z});
            end
            next_done = 1'b0;
            if (rst) begin
                m_running   = 1'b0;
                m_remaining = 0;
                m_prod      = '0;
                m_long      = 1'b0;
                m_sf        = 1'b0;
                m_lo        = '0;
                m_hi        = '0;
                m_n         = 1'b0;
                m_z         = 1'b0;
            end else if (m_running) begin
                if (flush) begin
                    m_running = 1'b0;
                end else begin
                    m_remaining--;
                    if (m_remaining == 0) begin
                        m_running = 1'b0;
                        next_done = 1'b1;
                        m_lo = m_prod[31:0];
                        m_hi = m_long ? m_prod[63:32] : 32'h0;
                        if (m_sf) begin
                            m_n = m_long ? m_prod[63] : m_prod[31];
                            m_z = m_long ? (m_prod == 64'h0) : (m_prod[31:0] == 32'h0);
                        end
                    end
                end
            end else if (start && !flush) begin
                m_running   = 1'b1;
                m_remaining = run_cycles(op_b);
                m_prod      = {32'h0, op_a} * {32'h0, op_b};
                m_long      = long_op;
                m_sf        = set_flags;
            end
            m_done = next_done;
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int cyc;
        int cyc2;
        int done_count;
        int lat_mul;
        int lat_b2b;
        int lat_zero;
        int lat_top;
        logic [31:0] flush_b;
        logic [31:0] rb;

`ifdef MUL_EARLY_TERM_EN
        lat_mul  = 4;
        lat_b2b  = 3;
        lat_zero = 2;
        flush_b  = 32'h4000_0005;
`else
        lat_mul  = 33;
        lat_b2b  = 33;
        lat_zero = 33;
        flush_b  = 32'h0000_0005;
`endif
        lat_top = 33;

        // Reset then idle
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) idle_cycle();
        @(negedge clk);
        checkOutput("idle_stall", {63'd0, stall}, 64'd0);
        checkOutput("idle_done",  {63'd0, done},  64'd0);
        checkOutput("idle_lo",    {32'd0, res_lo}, 64'd0);

        // MUL 7*6 with flags
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 32'd6);
        wait_done(cyc);
        checkOutput("mul_latency", 64'(cyc), 64'(lat_mul));
        checkOutput("mul_lo", {32'd0, res_lo}, 64'd42);
        checkOutput("mul_hi", {32'd0, res_hi}, 64'd0);
        checkOutput("mul_n",  {63'd0, flag_n}, 64'd0);
        checkOutput("mul_z",  {63'd0, flag_z}, 64'd0);

        // UMULL max*max
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        checkOutput("umull_lo", {32'd0, res_lo}, 64'h0000_0001);
        checkOutput("umull_hi", {32'd0, res_hi}, 64'hFFFF_FFFE);
        checkOutput("umull_n",  {63'd0, flag_n}, 64'd1);
        checkOutput("umull_z",  {63'd0, flag_z}, 64'd0);

        // Flush at cycle 10 of an in-flight operation
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, flush_b);
        for (int i = 1; i <= 9; i++) idle_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("flush_busy_c10", {63'd0, busy}, 64'd1);
        idle_cycle();
        @(negedge clk);
        checkOutput("flush_busy_c11", {63'd0, busy}, 64'd0);
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            idle_cycle();
            @(negedge clk);
            if (done === 1'b1) done_count++;
        end
        checkOutput("flush_no_done", 64'(done_count), 64'd0);
        checkOutput("flush_keep_lo", {32'd0, res_lo}, 64'h0000_0001);
        checkOutput("flush_keep_hi", {32'd0, res_hi}, 64'hFFFF_FFFE);
        checkOutput("flush_keep_n",  {63'd0, flag_n}, 64'd1);

        // Back-to-back with i_Start held through RUN and DONE
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2);
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3);
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        checkOutput("b2b_first_lat", 64'(cyc), 64'(lat_b2b));
        checkOutput("b2b_first_lo", {32'd0, res_lo}, 64'd4);
        wait_done(cyc2);
        checkOutput("b2b_spacing", 64'(cyc2), 64'(lat_b2b));
        checkOutput("b2b_second_lo", {32'd0, res_lo}, 64'd9);

        // Multiplier zero with flags set
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12345, 32'd0);
        wait_done(cyc);
        checkOutput("zero_latency", 64'(cyc), 64'(lat_zero));
        checkOutput("zero_lo", {32'd0, res_lo}, 64'd0);
        checkOutput("zero_z",  {63'd0, flag_z}, 64'd1);

        // Multiplier with only the top bit set
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'h8000_0000);
        wait_done(cyc);
        checkOutput("top_latency", 64'(cyc), 64'(lat_top));
        checkOutput("top_lo", {32'd0, res_lo}, 64'h8000_0000);
        checkOutput("top_n",  {63'd0, flag_n}, 64'd1);

        // Reset in the middle of RUN aborts the operation and clears results
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd9, 32'hFFFF_0009);
        for (int i = 0; i < 5; i++) idle_cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            idle_cycle();
            @(negedge clk);
            if (done === 1'b1) done_count++;
        end
        checkOutput("rst_no_done", 64'(done_count), 64'd0);
        checkOutput("rst_lo", {32'd0, res_lo}, 64'd0);
        checkOutput("rst_n",  {63'd0, flag_n}, 64'd0);

        // Randomized traffic checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0),
                          $urandom, rb);
        end
        for (int i = 0; i < 40; i++) idle_cycle();
        @(negedge clk);
        @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Iterative radix-2 shift-add multiplier controller for the pipelined ARM core's Execute stage.
- Accepts MUL (32-bit result) and UMULL (64-bit result) operations from the decoded control path.
- Stalls the pipeline while the multiply runs, then presents the result and N/Z flags for writeback.
- Owns the multiply datapath registers and the IDLE/RUN/DONE sequencing FSM.

Parameters:
WIDTH, 32, operand width in bits; product width is 2*WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
i_CLK  in  1  clock
i_RST  in  1  synchronous reset, active-high
i_Start  in  1  multiply request from Execute, one-cycle pulse or held
i_Long  in  1  1 = UMULL (64-bit result), 0 = MUL (low word only)
i_Set_Flags  in  1  update o_N/o_Z at completion
i_Flush  in  1  abort the in-flight operation (branch taken / pipeline flush)
i_Op_A  in  WIDTH  multiplicand
i_Op_B  in  WIDTH  multiplier
o_Busy  out  1  FSM in RUN
o_Stall  out  1  pipeline stall request
o_Done  out  1  result-valid strobe, one cycle
o_Result_Lo  out  WIDTH  product[WIDTH-1:0]
o_Result_Hi  out  WIDTH  product[2*WIDTH-1:WIDTH]; 0 when i_Long was 0
o_N, o_Z  out  1 each  flags of the last flag-setting result

Behaviour:
- Clock and reset: one clock i_CLK; reset i_RST is synchronous and active-high.
- Reset: state=IDLE; all internal registers 0; o_Busy=0, o_Stall=0, o_Done=0, o_Result_Lo=0, o_Result_Hi=0, o_N=0, o_Z=0.
- Reset asserted mid-RUN: aborts the operation; no o_Done is produced.
- Registers: mcand (2*WIDTH, zero-extended A), mplier (WIDTH), acc (2*WIDTH), cnt (CNT_W), long_q, flags_q.
- IDLE:
  - i_Start=1 and i_Flush=0: load mcand={0,A}, mplier=B, acc=0, cnt=0; latch i_Long and i_Set_Flags; go to RUN.
  - i_Start together with i_Flush: ignored.
- RUN, each cycle:
  - If mplier[0]=1, acc <= acc + mcand (mod 2^(2*WIDTH)).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt==WIDTH-1, go to DONE on that edge.
- DONE, exactly one cycle:
  - o_Done=1.
  - o_Result_Lo=acc[WIDTH-1:0].
  - o_Result_Hi=long_q ? acc[2*WIDTH-1:WIDTH] : 0.
- Result hold: o_Result_* are registered on entry to DONE and held until the next DONE.
- Flags: if the latched set-flags bit is 1, on entry to DONE o_N/o_Z are updated; otherwise both are unchanged.
  - Long: o_N=acc[2*WIDTH-1], o_Z=(acc==0).
  - Short: o_N=acc[WIDTH-1], o_Z=(acc[WIDTH-1:0]==0).
- DONE next state:
  - i_Start=1 (back-to-back): reload as in IDLE and go to RUN.
  - Otherwise: go to IDLE.
- o_Stall (combinational): 1 in RUN; 1 in IDLE/DONE when i_Start=1 and i_Flush=0; 0 otherwise.
- o_Busy = (state==RUN).
- Latency: with the start sampled at edge k, o_Done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
- i_Start during RUN: ignored, with no queueing.
- i_Flush during RUN: go to IDLE next edge; o_Done is not asserted; result and flag registers are unchanged.
- i_Flush during DONE: o_Done is still asserted (the result is already committed); any i_Start in that cycle is ignored.

Optional Feature:
MUL_EARLY_TERM_EN
- Defined: in RUN, when the post-shift mplier becomes 0, go to DONE on that edge. acc is then already final.
  - Minimum latency: 2 cycles (B=0 or B=1).
  - Latency for B with top set bit at position p: p+2 cycles.
- Undefined: fixed WIDTH+1 latency, independent of operand values.

Test Plan:
- Reset then idle: all outputs 0; i_Start=0 for 10 cycles -> o_Stall=0, o_Done=0.
- MUL: A=7, B=6, i_Long=0, i_Set_Flags=1 -> o_Done exactly 33 cycles after start (macro off); Lo=42, Hi=0, N=0, Z=0; o_Stall high for cycles 0..32.
- UMULL: A=0xFFFFFFFF, B=0xFFFFFFFF, i_Long=1, i_Set_Flags=1 -> Lo=0x00000001, Hi=0xFFFFFFFE, N=1, Z=0.
- Flush: start A=3, B=5, assert i_Flush at cycle 10 -> state IDLE at cycle 11, no o_Done; previous result/flags retained.
- Back-to-back: hold i_Start through DONE with A=2, B=2 then A=3, B=3 -> two o_Done pulses 33 cycles apart, results 4 then 9; mid-RUN i_Start ignored.
- MUL_EARLY_TERM_EN defined: B=0 -> o_Done 2 cycles after start, Lo=0, Z=1 (flags set); B=0x80000000, A=1 -> o_Done at cycle 33, Lo=0x80000000, N=1.
